// File: rtl/framebuffer_read_sequencer.sv
// Framebuffer read sequencer: issues row/bit-plane/channel read addresses one RAM latency ahead of
// the LED driver's STREAM-mode data slots, drives the multiplex row select and tracks the displayed slice.
module framebuffer_read_sequencer #(
    parameter int BLANKING_TIME = 72,
    parameter int NB_MUX        = 8,
    parameter int NB_SLICES     = 128,
    parameter int POKER_BITS    = 9,
    parameter int CHANNELS      = 48,
    parameter int READ_LATENCY  = 1
) (
    input  logic                         clk_lse,
    input  logic                         rst,
    input  logic                         stream_en,
    input  logic                         position_sync,
    output logic                         framebuffer_sync,
    output logic                         fb_rd_en,
    output logic [$clog2(NB_SLICES)-1:0] fb_rd_slice,
    output logic [$clog2(NB_MUX)-1:0]    fb_rd_mux,
    output logic [3:0]                   fb_rd_bit,
    output logic [5:0]                   fb_rd_chan,
    output logic [NB_MUX-1:0]            mux_sel,
    output logic [$clog2(NB_SLICES)-1:0] slice_index,
    output logic                         resync_err
);

    localparam int SEG_LEN = BLANKING_TIME + POKER_BITS * (CHANNELS + 1);
    localparam int SEG_W   = $clog2(SEG_LEN);
    localparam int SL_W    = $clog2(NB_SLICES);
    localparam int MX_W    = $clog2(NB_MUX);

    localparam logic [SEG_W-1:0] SEG_LAST   = SEG_W'(SEG_LEN - 1);
    localparam logic [SEG_W-1:0] BLANK_CNT  = SEG_W'(BLANKING_TIME);
    localparam logic [SEG_W-1:0] LAT_CNT    = SEG_W'(READ_LATENCY);
    localparam logic [MX_W-1:0]  ROW_LAST   = MX_W'(NB_MUX - 1);
    localparam logic [SL_W-1:0]  SLICE_LAST = SL_W'(NB_SLICES - 1);
    localparam logic [5:0]       CHAN_LAST  = 6'(CHANNELS);
    localparam logic [3:0]       TOP_PLANE  = 4'(POKER_BITS - 1);

    // A lookahead longer than the blanking would have to start reading while still ARMED.
    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4 || READ_LATENCY > BLANKING_TIME) begin : g_bad_latency
            $error("framebuffer_read_sequencer: READ_LATENCY must be 1..4 and not exceed BLANKING_TIME");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    state_t            state, state_next;
    logic [SEG_W-1:0]  seg_cnt;
    logic [MX_W-1:0]   row_cnt;
    logic              pending;
    logic [SEG_W-1:0]  la_cnt;
    logic [5:0]        la_pos;
    logic [3:0]        la_grp;

    logic              seg_wrap, row_wrap, slice_boundary, force_zero, la_cross;
    logic [SL_W-1:0]   slice_natural, la_slice;
    logic [MX_W-1:0]   la_row;

    assign seg_wrap       = (seg_cnt == SEG_LAST);
    assign row_wrap       = (row_cnt == ROW_LAST);
    assign slice_boundary = (state == RUN) && seg_wrap && row_wrap;
    assign force_zero     = pending || position_sync;
    assign slice_natural  = (slice_index == SLICE_LAST) ? '0 : slice_index + 1'b1;

    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        state_next       = state;
        framebuffer_sync = 1'b0;
        case (state)
            IDLE:  if (stream_en) state_next = ARMED;
            ARMED: begin
                if (position_sync) begin
                    framebuffer_sync = 1'b1;
                    state_next       = RUN;
                end else if (!stream_en) begin
                    state_next = IDLE;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk_lse) begin
        if (rst) begin
            state       <= IDLE;
            seg_cnt     <= '0;
            row_cnt     <= '0;
            slice_index <= '0;
            pending     <= 1'b0;
            resync_err  <= 1'b0;
            la_cnt      <= '0;
            la_pos      <= '0;
            la_grp      <= '0;
        end else begin
            state <= state_next;
            case (state)
                ARMED: begin
                    seg_cnt     <= '0;
                    row_cnt     <= '0;
                    slice_index <= '0;
                    pending     <= 1'b0;
                    la_cnt      <= LAT_CNT;
                    la_pos      <= '0;
                    la_grp      <= '0;
                end
                RUN: begin
                    seg_cnt <= seg_wrap ? '0 : seg_cnt + 1'b1;
                    if (seg_wrap) row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;

                    if (slice_boundary) begin
                        slice_index <= force_zero ? '0 : slice_natural;
                        pending     <= 1'b0;
                        if (force_zero && slice_natural != '0) resync_err <= 1'b1;
                    end else if (position_sync) begin
                        pending <= 1'b1;
                    end

                    // Lookahead walks the same segment pattern READ_LATENCY cycles early.
                    if (la_cnt == SEG_LAST) begin
                        la_cnt <= '0;
                        la_pos <= '0;
                        la_grp <= '0;
                    end else begin
                        la_cnt <= la_cnt + 1'b1;
                        if (la_cnt < BLANK_CNT) begin
                            la_pos <= '0;
                            la_grp <= '0;
                        end else if (la_pos == CHAN_LAST) begin
                            la_pos <= '0;
                            la_grp <= la_grp + 1'b1;
                        end else begin
                            la_pos <= la_pos + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        la_cross = (la_cnt < seg_cnt);
        la_row   = row_cnt;
        la_slice = slice_index;
        if (la_cross) begin
            la_row = row_wrap ? '0 : row_cnt + 1'b1;
            if (row_wrap) la_slice = force_zero ? '0 : slice_natural;
        end

        fb_rd_en    = (state == RUN) && (la_pos != '0);
        fb_rd_slice = '0;
        fb_rd_mux   = '0;
        fb_rd_bit   = '0;
        fb_rd_chan  = '0;
        if (fb_rd_en) begin
            fb_rd_slice = la_slice;
            fb_rd_mux   = la_row;
            fb_rd_bit   = TOP_PLANE - la_grp;
            fb_rd_chan  = CHAN_LAST - la_pos;
        end

        mux_sel = '0;
        if (state == RUN) mux_sel[row_cnt] = 1'b1;
    end

endmodule

// File: tb/tb_framebuffer_read_sequencer.sv
// Randomised bench for framebuffer_read_sequencer against a run-cycle-indexed reference model.
// NB_SLICES is reduced to 8 so a full revolution, and its natural wrap, fits in the run.
module tb_framebuffer_read_sequencer;

    localparam int BLANK     = 72;
    localparam int NB_MUX    = 8;
    localparam int NB_SLICES = 8;
    localparam int PB        = 9;
    localparam int CH        = 48;
    localparam int LAT       = 1;
    localparam int SEG_LEN   = BLANK + PB * (CH + 1);
    localparam int SLICE_LEN = SEG_LEN * NB_MUX;

    logic                         clk_lse = 1'b0;
    logic                         rst;
    logic                         stream_en;
    logic                         position_sync;
    logic                         framebuffer_sync;
    logic                         fb_rd_en;
    logic [$clog2(NB_SLICES)-1:0] fb_rd_slice;
    logic [$clog2(NB_MUX)-1:0]    fb_rd_mux;
    logic [3:0]                   fb_rd_bit;
    logic [5:0]                   fb_rd_chan;
    logic [NB_MUX-1:0]            mux_sel;
    logic [$clog2(NB_SLICES)-1:0] slice_index;
    logic                         resync_err;

    always #5 clk_lse = ~clk_lse;

    framebuffer_read_sequencer #(
        .BLANKING_TIME(BLANK),
        .NB_MUX       (NB_MUX),
        .NB_SLICES    (NB_SLICES),
        .POKER_BITS   (PB),
        .CHANNELS     (CH),
        .READ_LATENCY (LAT)
    ) dut (
        .clk_lse         (clk_lse),
        .rst             (rst),
        .stream_en       (stream_en),
        .position_sync   (position_sync),
        .framebuffer_sync(framebuffer_sync),
        .fb_rd_en        (fb_rd_en),
        .fb_rd_slice     (fb_rd_slice),
        .fb_rd_mux       (fb_rd_mux),
        .fb_rd_bit       (fb_rd_bit),
        .fb_rd_chan      (fb_rd_chan),
        .mux_sel         (mux_sel),
        .slice_index     (slice_index),
        .resync_err      (resync_err)
    );

    typedef enum {M_IDLE, M_ARMED, M_RUN} mode_t;

    mode_t m_mode    = M_IDLE;
    int    t         = 0;
    int    m_slice   = 0;
    bit    m_pending = 1'b0;
    bit    m_err     = 1'b0;
    int    seg_reads = 0;
    int    sync_seen = 0;
    int    n_checks  = 0;
    int    n_errors  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (run cycle %0d)", tag, got, exp, t);
        end
    endtask

    task automatic compare_outputs();
        int          la, off;
        bit          e_rd;
        logic [31:0] e_bit, e_chan, e_row, e_mux;
        e_rd   = 1'b0;
        e_bit  = '0;
        e_chan = '0;
        e_row  = '0;
        e_mux  = '0;
        if (m_mode == M_RUN) begin
            la    = (t + LAT) % SEG_LEN;
            off   = la - BLANK;
            e_row = 32'(((t + LAT) / SEG_LEN) % NB_MUX);
            if (off >= 0 && (off % (CH + 1)) != 0) begin
                e_rd   = 1'b1;
                e_bit  = 32'(PB - 1 - off / (CH + 1));
                e_chan = 32'(CH - off % (CH + 1));
            end
            e_mux = 32'(1) << ((t / SEG_LEN) % NB_MUX);
        end

        check("framebuffer_sync", 32'(framebuffer_sync), 32'(m_mode == M_ARMED && position_sync));
        check("fb_rd_en", 32'(fb_rd_en), 32'(e_rd));
        check("mux_sel", 32'(mux_sel), e_mux);
        check("slice_index", 32'(slice_index), (m_mode == M_RUN) ? 32'(m_slice) : 32'd0);
        check("resync_err", 32'(resync_err), 32'(m_err));
        if (e_rd || m_mode != M_RUN) begin
            check("fb_rd_slice", 32'(fb_rd_slice), e_rd ? 32'(m_slice) : 32'd0);
            check("fb_rd_mux", 32'(fb_rd_mux), e_row);
            check("fb_rd_bit", 32'(fb_rd_bit), e_bit);
            check("fb_rd_chan", 32'(fb_rd_chan), e_chan);
        end

        if (m_mode == M_RUN) begin
            if (fb_rd_en) seg_reads++;
            if (t % SEG_LEN == SEG_LEN - 1) begin
                check("reads_per_segment", 32'(seg_reads), 32'(PB * CH));
                seg_reads = 0;
            end
        end
        if (framebuffer_sync) sync_seen++;
    endtask

    task automatic model_step();
        int nat;
        if (rst) begin
            m_mode    = M_IDLE;
            t         = 0;
            m_slice   = 0;
            m_pending = 1'b0;
            m_err     = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (stream_en) m_mode = M_ARMED;
                M_ARMED: begin
                    if (position_sync) begin
                        m_mode    = M_RUN;
                        t         = 0;
                        m_slice   = 0;
                        m_pending = 1'b0;
                        seg_reads = 0;
                    end else if (!stream_en) begin
                        m_mode = M_IDLE;
                    end
                end
                M_RUN: begin
                    if (t % SLICE_LEN == SLICE_LEN - 1) begin
                        nat = (m_slice + 1) % NB_SLICES;
                        if (m_pending || position_sync) begin
                            if (nat != 0) m_err = 1'b1;
                            m_slice = 0;
                        end else begin
                            m_slice = nat;
                        end
                        m_pending = 1'b0;
                    end else if (position_sync) begin
                        m_pending = 1'b1;
                    end
                    t++;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic cycle(input logic r, input logic se, input logic ps);
        rst           = r;
        stream_en     = se;
        position_sync = ps;
        #1;
        compare_outputs();
        model_step();
        @(posedge clk_lse);
        #1;
    endtask

    initial begin
        int  rev_pulse, mid_pulse;
        logic ps;
        rst           = 1'b1;
        stream_en     = 1'b1;
        position_sync = 1'b0;
        @(posedge clk_lse);
        #1;

        // Reset with stream_en held high, then sit ARMED without a sync pulse.
        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        repeat (20) cycle(1'b0, 1'b1, 1'b0);
        // Dropping stream_en while ARMED falls back to IDLE; re-arm afterwards.
        repeat ($urandom_range(2, 6)) cycle(1'b0, 1'b0, 1'b0);
        repeat ($urandom_range(5, 12)) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);

        rev_pulse = 7 * SLICE_LEN + int'($urandom_range(0, SLICE_LEN - 1));
        mid_pulse = 13 * SLICE_LEN + int'($urandom_range(100, SLICE_LEN - 200));
        while (t < 14 * SLICE_LEN + 300) begin
            if (t == SLICE_LEN) begin
                check("first_slice_advance", 32'(slice_index), 32'd1);
                check("first_slice_mux", 32'(mux_sel), 32'h01);
            end
            if (t == 8 * SLICE_LEN) begin
                check("wrap_slice", 32'(slice_index), 32'd0);
                check("wrap_no_err", 32'(resync_err), 32'd0);
            end
            if (t == 14 * SLICE_LEN) begin
                check("resync_slice", 32'(slice_index), 32'd0);
                check("resync_err_set", 32'(resync_err), 32'd1);
            end
            ps = (t == rev_pulse) || (t == mid_pulse) || (t == mid_pulse + 17);
            cycle(1'b0, 1'($urandom_range(0, 1)), ps);
        end

        // Synchronous reset in the middle of a segment, then a fresh arm/sync.
        while (t % SEG_LEN != 300) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("post_reset_mux", 32'(mux_sel), 32'd0);
        check("post_reset_rd", 32'(fb_rd_en), 32'd0);
        check("post_reset_err", 32'(resync_err), 32'd0);
        repeat ($urandom_range(3, 8)) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        repeat (SEG_LEN + 100) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        check("sync_pulses", 32'(sync_seen), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/framebuffer_read_sequencer.md
Name: framebuffer_read_sequencer

Overview:
- Sequences framebuffer reads so that `framebuffer_dat` reaching the LED driver controller is aligned with its STREAM-mode SCLK/LAT timing.
- Within every 513-cycle GCLK segment it generates read addresses for one multiplex row: 9 poker bit-planes of 48 channels each.
- It drives the one-hot multiplex row select, tracks the current slice index and resynchronises that index to a rotation-position pulse.
- It sits between the framebuffer RAM and the driver controller and issues the `framebuffer_sync` that starts streaming.

Parameters:
- BLANKING_TIME, 72, SCLK-idle cycles at the start of each segment.
- NB_MUX, 8, multiplex rows per slice.
- NB_SLICES, 128, slices per revolution.
- POKER_BITS, 9, bit-planes per segment.
- CHANNELS, 48, shift bits per WRTGS group.
- READ_LATENCY, 1, framebuffer RAM read latency in cycles (1..4).

Ports:
- clk_lse  in  1  system/LSE clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- stream_en  in  1  driver configuration finished; level.
- position_sync  in  1  one-cycle pulse at rotation index (slice 0).
- framebuffer_sync  out  1  one-cycle pulse: first segment of streaming starts next cycle.
- fb_rd_en  out  1  framebuffer read strobe.
- fb_rd_slice  out  $clog2(NB_SLICES)  slice field of the read address.
- fb_rd_mux  out  $clog2(NB_MUX)  row field of the read address.
- fb_rd_bit  out  4  bit-plane field of the read address; MSB plane first.
- fb_rd_chan  out  6  channel field of the read address.
- mux_sel  out  NB_MUX  one-hot row enable for the LED columns.
- slice_index  out  $clog2(NB_SLICES)  slice currently displayed.
- resync_err  out  1  sticky: `position_sync` arrived when the slice index was not at the expected wrap point.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-RUN aborts immediately; no flush.
- State IDLE: wait for `stream_en`=1, then go to ARMED.
- State ARMED: on `position_sync`, pulse `framebuffer_sync` for 1 cycle, set `slice_index`=0 and go to RUN.
- Dropping `stream_en` in ARMED returns to IDLE. Dropping it in RUN has no effect: the controller streams forever.
- RUN counters:
  - `seg_cnt` runs 0..512 (513 cycles) and wraps.
  - `row_cnt` runs 0..NB_MUX-1 and advances when `seg_cnt` wraps.
  - The slice index advances when `row_cnt` wraps, modulo NB_SLICES.
  - The first RUN cycle has `seg_cnt`=0.
- Data cycles within a segment:
  - seg_cnt in [BLANKING_TIME, 512]; let off = seg_cnt − BLANKING_TIME.
  - group = off/49, pos = off%49.
  - pos=0 is the post-WRTGS pause (no data).
  - pos=1..48 carries the bit of channel 48−pos (47 down to 0), bit-plane POKER_BITS−1−group.
  - 72 + 9×49 = 513, so the last data bit lands at seg_cnt=512.
- Read timing:
  - `fb_rd_en`=1 with fields {slice_index, row_cnt, bit, chan} exactly READ_LATENCY cycles before each data cycle.
  - Implementation: an internal lookahead counter leads `seg_cnt` by READ_LATENCY. Reads for segment k+1 may therefore be issued during the tail of segment k, carrying k+1's row and slice.
  - `fb_rd_en`=0 in IDLE and ARMED, except for ARMED lookahead when READ_LATENCY > BLANKING_TIME. That case is not allowed; a parameter assertion must fire.
- `mux_sel`:
  - One-hot `1<<row_cnt` in RUN, updated on the cycle `seg_cnt` returns to 0, i.e. inside blanking.
  - 0 outside RUN.
- Resync:
  - A `position_sync` in RUN is held in a pending flag.
  - At the next slice boundary (`row_cnt` and `seg_cnt` both wrapping), the pending flag forces the next slice to 0 and clears.
  - If the forced value differs from the natural increment, set `resync_err`; it is cleared only by reset.
  - A second pulse while pending is already set is ignored.
  - A pulse coinciding with the boundary cycle applies at that boundary.
- `framebuffer_sync` is never reasserted while in RUN.

Test Plan:
- Reset with `stream_en`=1 and no `position_sync` → state stays ARMED; all outputs 0; `fb_rd_en` never 1.
- `stream_en`=1, then `position_sync` at cycle 10 → `framebuffer_sync` high only at cycle 10; `mux_sel`=8'h01 from cycle 11.
  - READ_LATENCY=1: first `fb_rd_en` at RUN cycle 72 (seg_cnt 72) with bit=8, chan=47. The RUN cycle 72 pause and data at 73 hold under the lookahead offset.
- Count RUN reads over one segment → exactly 432 `fb_rd_en` pulses.
  - A gap of exactly one idle cycle between every 48 reads.
  - Channel sequence 47..0 repeated for bits 8..0.
- Run 8 segments → `mux_sel` walks 01,02,…,80, then returns to 01 with `slice_index` incremented to 1. Last read of segment 7 carries slice 0, row 7.
- `position_sync` mid-slice 5 → at the slice-5 boundary `slice_index` becomes 0 and `resync_err`=1. Pulse at the natural wrap from NB_SLICES−1 → `slice_index`=0, `resync_err` stays 0.
- Assert `rst` at seg_cnt 300 of RUN → next cycle all outputs 0 and state IDLE. Re-arming produces a fresh `framebuffer_sync`.
